// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter and cycle sequencer for a single-port 2048x16 memory.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration (default: strict data priority).
//
// state   | meaning
// IDLE    | no access in flight; grant one requester, pulse last response
// RD_ADDR | address presented, memory captures word into its output register
// RD_DATA | memory drives bus (oe=1), word captured into requester's rdata
// WR      | address and write data driven, we=1, memory commits at edge
module mem_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic                  mem_output_enable,
  output logic                  mem_reset,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  tag_d_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic                  if_rvalid_q;
  logic                  d_done_q;

  logic if_grant;
  logic d_grant;
  logic accept;

`ifdef MEM_ARB_RR_EN
  // 1 = data port won the last grant, 0 = fetch port did
  logic last_d_q;

  always_comb begin
    d_grant  = d_valid && (!if_valid || !last_d_q);
    if_grant = if_valid && (!d_valid || last_d_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_d_q <= 1'b0;
    end else if (accept) begin
      last_d_q <= d_ready;
    end
  end
`else
  always_comb begin
    d_grant  = d_valid;
    if_grant = if_valid && !d_valid;
  end
`endif

  // Ready is masked by reset so requesters never see a handshake while held in reset
  always_comb begin
    d_ready  = reset && (state == IDLE) && d_grant;
    if_ready = reset && (state == IDLE) && if_grant;
    accept   = d_ready || if_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_ready && d_we) begin
          state_next = WR;
        end else if (accept) begin
          state_next = RD_ADDR;
        end
      end
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: state_next = IDLE;
      WR:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      tag_d_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_done_q    <= 1'b0;
      if (accept) begin
        addr_q  <= d_ready ? d_addr : if_addr;
        wdata_q <= d_wdata;
        tag_d_q <= d_ready;
      end
      if (state == RD_DATA) begin
        if (tag_d_q) begin
          d_rdata_q <= mem_data;
          d_done_q  <= 1'b1;
        end else begin
          if_rdata_q  <= mem_data;
          if_rvalid_q <= 1'b1;
        end
      end
      if (state == WR) begin
        d_done_q <= 1'b1;
      end
    end
  end

  // addr_q only changes on a handshake, so the address holds its last value while idle
  assign mem_address       = addr_q;
  assign mem_write_enable  = (state == WR);
  assign mem_output_enable = (state == RD_DATA);
  assign mem_reset         = ~reset;
  assign mem_data          = (state == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural 2048x16 memory, response scoreboard,
// and one task per scenario.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [10:0] if_addr = '0;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic        d_we = 1'b0;
  logic [10:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_done;
  logic [15:0] d_rdata;
  logic [10:0] mem_address;
  logic        mem_write_enable;
  logic        mem_output_enable;
  logic        mem_reset;
  wire  [15:0] mem_data;
  logic        busy;

  mem_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .if_valid          (if_valid),
    .if_ready          (if_ready),
    .if_addr           (if_addr),
    .if_rvalid         (if_rvalid),
    .if_rdata          (if_rdata),
    .d_valid           (d_valid),
    .d_ready           (d_ready),
    .d_we              (d_we),
    .d_addr            (d_addr),
    .d_wdata           (d_wdata),
    .d_done            (d_done),
    .d_rdata           (d_rdata),
    .mem_address       (mem_address),
    .mem_write_enable  (mem_write_enable),
    .mem_output_enable (mem_output_enable),
    .mem_reset         (mem_reset),
    .mem_data          (mem_data),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with a registered read output
  logic [15:0] mem [2048];
  logic [15:0] mem_out_q;

  always @(posedge clk) begin
    if (mem_reset) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 16'h0000;
      mem_out_q <= 16'h0000;
    end else begin
      if (mem_write_enable) mem[mem_address] <= mem_data;
      mem_out_q <= mem[mem_address];
    end
  end

  assign mem_data = mem_output_enable ? mem_out_q : 16'bz;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] shadow [2048];
  int          vecs = 0;
  int          errs = 0;
  bit          mon_en = 1'b0;

  task automatic clear_shadow();
    for (int i = 0; i < 2048; i++) shadow[i] = 16'h0000;
  endtask

  // Advance to the next falling edge and check bus rules and any response pulse there
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (mon_en) begin
      vecs++;
      if (mem_write_enable && mem_output_enable) begin
        errs++;
        $display("FAIL oe_we_overlap: we=%0b oe=%0b at cycle %0d, required not both 1",
                 mem_write_enable, mem_output_enable, cyc);
      end
      if (d_done) begin
        vecs++;
        if (sbq.size() == 0 || !sbq[0].is_d) begin
          errs++;
          $display("FAIL d_done_unexpected: d_done=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sbq.pop_front();
          if (cyc != e.due) begin
            errs++;
            $display("FAIL d_done_latency: pulse at cycle %0d, required cycle %0d", cyc, e.due);
          end
          if (!e.we && d_rdata !== e.data) begin
            errs++;
            $display("FAIL d_rdata: got %h, required %h", d_rdata, e.data);
          end
        end
      end
      if (if_rvalid) begin
        vecs++;
        if (sbq.size() == 0 || sbq[0].is_d) begin
          errs++;
          $display("FAIL if_rvalid_unexpected: if_rvalid=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sbq.pop_front();
          if (cyc != e.due) begin
            errs++;
            $display("FAIL if_rvalid_latency: pulse at cycle %0d, required cycle %0d", cyc, e.due);
          end
          if (if_rdata !== e.data) begin
            errs++;
            $display("FAIL if_rdata: got %h, required %h", if_rdata, e.data);
          end
        end
      end
    end
  endtask

  task automatic push_exp(input logic is_d, input logic we, input logic [10:0] addr,
                          input logic [15:0] wdata);
    exp_t e;
    e.is_d = is_d;
    e.we   = we;
    e.data = we ? wdata : shadow[addr];
    e.due  = cyc + (we ? 2 : 3);
    if (we) shadow[addr] = wdata;
    sbq.push_back(e);
  endtask

  // Single request; returns at the falling edge just after the handshake edge
  task automatic req(input logic is_d, input logic we, input logic [10:0] addr,
                     input logic [15:0] wdata);
    bit got = 1'b0;
    if (is_d) begin
      d_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_valid = 1'b1; if_addr = addr;
    end
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (is_d ? d_ready : if_ready) begin
        got = 1'b1;
        push_exp(is_d, we, addr, wdata);
      end
      tick();
    end
    d_valid = 1'b0; if_valid = 1'b0;
    d_addr = ~addr; if_addr = ~addr; d_wdata = ~wdata; d_we = ~we;
    vecs++;
    if (!got) begin
      errs++;
      $display("FAIL req_timeout: port_d=%0b addr=%h got no ready, required ready", is_d, addr);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sbq.size() > 0; k++) tick();
    vecs++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    d_valid = 1'b1; d_we = 1'b1; d_addr = 11'h155; d_wdata = 16'hA5A5;
    if_valid = 1'b1; if_addr = 11'h2AA;
    tick();
    tick();
    #1;
    vecs++;
    if ({if_ready, d_ready, if_rvalid, d_done, busy, mem_write_enable, mem_output_enable} !== 7'b0) begin
      errs++;
      $display("FAIL reset_ctrl: ir=%0b dr=%0b rv=%0b dd=%0b busy=%0b we=%0b oe=%0b, required all 0",
               if_ready, d_ready, if_rvalid, d_done, busy, mem_write_enable, mem_output_enable);
    end
    vecs++;
    if (if_rdata !== 16'h0 || d_rdata !== 16'h0 || mem_address !== 11'h0) begin
      errs++;
      $display("FAIL reset_data: if_rdata=%h d_rdata=%h addr=%h, required 0",
               if_rdata, d_rdata, mem_address);
    end
    vecs++;
    if (mem_reset !== 1'b1) begin
      errs++;
      $display("FAIL reset_mem_reset: got %0b, required 1", mem_reset);
    end
    d_valid = 1'b0; if_valid = 1'b0; d_we = 1'b0;
    reset = 1'b1;
    tick();
    vecs++;
    if (busy !== 1'b0 || mem_reset !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: busy=%0b mem_reset=%0b, required 0/0", busy, mem_reset);
    end
    clear_shadow();
    mon_en = 1'b1;
  endtask

  task automatic test_write_read();
    req(1'b1, 1'b1, 11'h005, 16'h1234);
    vecs++;
    if (busy !== 1'b1 || mem_write_enable !== 1'b1 || mem_address !== 11'h005) begin
      errs++;
      $display("FAIL wr_state: busy=%0b we=%0b addr=%h, required 1/1/005",
               busy, mem_write_enable, mem_address);
    end
    drain();
    req(1'b1, 1'b0, 11'h005, 16'h0000);
    vecs++;
    if (busy !== 1'b1 || mem_output_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
      errs++;
      $display("FAIL rd_addr_state: busy=%0b oe=%0b we=%0b, required 1/0/0",
               busy, mem_output_enable, mem_write_enable);
    end
    tick();
    vecs++;
    if (mem_output_enable !== 1'b1) begin
      errs++;
      $display("FAIL rd_data_oe: oe=%0b, required 1", mem_output_enable);
    end
    drain();
    vecs++;
    if (d_rdata !== 16'h1234 || mem_address !== 11'h005) begin
      errs++;
      $display("FAIL rd_hold: d_rdata=%h addr=%h, required 1234/005", d_rdata, mem_address);
    end
  endtask

  task automatic test_fetch();
    req(1'b1, 1'b1, 11'h7FF, 16'hBEEF);
    drain();
    req(1'b0, 1'b0, 11'h7FF, 16'h0000);
    drain();
    vecs++;
    if (if_rdata !== 16'hBEEF || d_rdata !== 16'h1234) begin
      errs++;
      $display("FAIL fetch_result: if_rdata=%h d_rdata=%h, required BEEF/1234", if_rdata, d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom);
      req(1'b1, 1'b1, 11'(11'h100 + i), v);
    end
    for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 11'(11'h100 + i), 16'h0000);
    for (int i = 3; i >= 0; i--) req(1'b0, 1'b0, 11'(11'h100 + i), 16'h0000);
    drain();
  endtask

  task automatic test_arbitration();
    logic grants [4];
    logic exp_g;
    int   n = 0;
    d_valid = 1'b1; d_we = 1'b0; d_addr = 11'h005;
    if_valid = 1'b1; if_addr = 11'h7FF;
    for (int k = 0; k < 60 && n < 4; k++) begin
      #1;
      if (d_ready && if_ready) begin
        errs++;
        $display("FAIL dual_grant: both ready at cycle %0d, required one", cyc);
      end
      if (d_ready) begin
        grants[n] = 1'b1; n++;
        push_exp(1'b1, 1'b0, 11'h005, 16'h0000);
      end else if (if_ready) begin
        grants[n] = 1'b0; n++;
        push_exp(1'b0, 1'b0, 11'h7FF, 16'h0000);
      end
      tick();
    end
    d_valid = 1'b0; if_valid = 1'b0;
    drain();
    vecs++;
    if (n != 4) begin
      errs++;
      $display("FAIL arb_timeout: %0d grants seen, required 4", n);
    end
    for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_g = (i % 2 == 0);
`else
      exp_g = 1'b1;
`endif
      vecs++;
      if (grants[i] !== exp_g) begin
        errs++;
        $display("FAIL arb_order[%0d]: granted data=%0b, required data=%0b", i, grants[i], exp_g);
      end
    end
  endtask

  task automatic test_reset_midop();
    req(1'b1, 1'b0, 11'h005, 16'h0000);
    void'(sbq.pop_back());
    tick();
    vecs++;
    if (busy !== 1'b1 || mem_output_enable !== 1'b1) begin
      errs++;
      $display("FAIL midop_rd_data: busy=%0b oe=%0b, required 1/1", busy, mem_output_enable);
    end
    reset = 1'b0;
    tick();
    vecs++;
    if (busy !== 1'b0 || d_done !== 1'b0 || if_rvalid !== 1'b0 || mem_reset !== 1'b1) begin
      errs++;
      $display("FAIL midop_reset: busy=%0b d_done=%0b if_rvalid=%0b mem_reset=%0b, required 0/0/0/1",
               busy, d_done, if_rvalid, mem_reset);
    end
    reset = 1'b1;
    clear_shadow();
    tick();
    vecs++;
    if (busy !== 1'b0 || d_done !== 1'b0) begin
      errs++;
      $display("FAIL midop_after: busy=%0b d_done=%0b, required 0/0", busy, d_done);
    end
    req(1'b0, 1'b0, 11'h005, 16'h0000);
    drain();
  endtask

  initial begin
    clear_shadow();
    test_reset();
    test_write_read();
    test_fetch();
    test_back_to_back();
    test_arbitration();
    test_reset_midop();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
